jacobian_to_affine: RTL and testbench

//  Converts a Jacobian point (X,Y,Z) mod p back to affine: x = X*Z^-2, y = Y*Z^-3 (mod p).

---
 rtl/jacobian_to_affine_if.sv | 27 ++
 rtl/jacobian_to_affine.sv | 293 +++++++++++++++++++++++++++++
 tb/tb_jacobian_to_affine.sv | 191 +++++++++++++++++++
 3 files changed

// File: rtl/jacobian_to_affine_if.sv
// Bundles the conversion request and result signals of jacobian_to_affine.
//   master : drives i_start, p, X, Y, Z; observes x_aff, y_aff, o_inf, o_busy, o_done
//   slave  : the converter itself
interface jacobian_to_affine_if #(
    parameter int WIDTH = 256
);
    logic             i_start;
    logic [WIDTH-1:0] p;
    logic [WIDTH-1:0] X;
    logic [WIDTH-1:0] Y;
    logic [WIDTH-1:0] Z;
    logic [WIDTH-1:0] x_aff;
    logic [WIDTH-1:0] y_aff;
    logic             o_inf;
    logic             o_busy;
    logic             o_done;

    modport master (
        output i_start, p, X, Y, Z,
        input  x_aff, y_aff, o_inf, o_busy, o_done
    );

    modport slave (
        input  i_start, p, X, Y, Z,
        output x_aff, y_aff, o_inf, o_busy, o_done
    );
endinterface

// File: rtl/jacobian_to_affine.sv
// Jacobian (X,Y,Z) mod p to affine conversion: x = X*Z^-2, y = Y*Z^-3.
// Z^-1 is formed as Z^(p-2) by left-to-right square-and-multiply, all on a
// single modular_multiplication instance sequenced by the FSM below.
//
// Ports:
//   i_clk  clock
//   i_rst  synchronous reset, active-high
//   bus    jacobian_to_affine_if.slave
//            i_start      start request, sampled only in IDLE
//            p, X, Y, Z   modulus and Jacobian point, latched on accepted start
//            x_aff/y_aff  affine result, held until the next conversion completes
//            o_inf        result is the point at infinity (Z == 0)
//            o_busy       conversion in progress
//            o_done       one-cycle completion pulse
//
// Build option: define JAC_ZONE_BYPASS_EN to short-circuit Z == 1 (result is
// X, Y directly, no multiplications). Without it Z == 1 takes the full path.
//
// state     | meaning
// ----------+--------------------------------------------------------------
// IDLE      | waiting for i_start
// CHK       | classify Z (zero / one with bypass / general)
// ZERO      | publish the short-path result (infinity or bypassed X,Y)
// EXP_SQ    | acc = acc*acc for exponent bit idx
// EXP_MUL   | acc = acc*Z when exponent bit idx is set
// ZI2       | zi2 = Z^-2
// ZI3       | zi3 = Z^-3
// XA        | x = X*zi2
// YA        | y = Y*zi3, publish result
// DONE      | o_done pulse cycle, back to IDLE

// Bit-serial interleaved modular multiplier, STEP multiplier bits per cycle.
// Requires a, b < m. ready pulses WIDTH/STEP cycles after the start cycle.
module modular_multiplication #(
    parameter int WIDTH = 256,
    parameter int STEP  = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [WIDTH-1:0] m,
    output logic [WIDTH-1:0] p,
    output logic             ready
);
    localparam int NSTEP = WIDTH / STEP;
    localparam int CW    = $clog2(NSTEP + 1);

    logic [WIDTH-1:0] a_q, b_q, m_q;
    logic [WIDTH:0]   r_q, r_c;
    logic [CW-1:0]    cnt_q;
    logic             run_q;

    // r stays below m at every step, so 2r and r+a both fit in WIDTH+1 bits
    // and a single conditional subtract restores r < m.
    always_comb begin
        r_c = r_q;
        for (int k = 0; k < STEP; k++) begin
            r_c = {r_c[WIDTH-1:0], 1'b0};
            if (r_c >= {1'b0, m_q}) r_c = r_c - {1'b0, m_q};
            if (b_q[WIDTH-1-k]) r_c = r_c + {1'b0, a_q};
            if (r_c >= {1'b0, m_q}) r_c = r_c - {1'b0, m_q};
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            a_q   <= '0;
            b_q   <= '0;
            m_q   <= '0;
            r_q   <= '0;
            cnt_q <= '0;
            run_q <= 1'b0;
            p     <= '0;
            ready <= 1'b0;
        end else begin
            ready <= 1'b0;
            if (start && !run_q) begin
                a_q   <= a;
                b_q   <= b;
                m_q   <= m;
                r_q   <= '0;
                cnt_q <= CW'(NSTEP);
                run_q <= 1'b1;
            end else if (run_q) begin
                r_q   <= r_c;
                b_q   <= b_q << STEP;
                cnt_q <= cnt_q - CW'(1);
                if (cnt_q == CW'(1)) begin
                    run_q <= 1'b0;
                    ready <= 1'b1;
                    p     <= r_c[WIDTH-1:0];
                end
            end
        end
    end
endmodule

module jacobian_to_affine #(
    parameter int WIDTH = 256
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    jacobian_to_affine_if.slave   bus
);
    localparam int IW       = $clog2(WIDTH);
    localparam int MUL_STEP = (WIDTH % 16 == 0) ? 16 : 1;

    localparam logic [3:0] S_IDLE    = 4'd0;
    localparam logic [3:0] S_CHK     = 4'd1;
    localparam logic [3:0] S_ZERO    = 4'd2;
    localparam logic [3:0] S_EXP_SQ  = 4'd3;
    localparam logic [3:0] S_EXP_MUL = 4'd4;
    localparam logic [3:0] S_ZI2     = 4'd5;
    localparam logic [3:0] S_ZI3     = 4'd6;
    localparam logic [3:0] S_XA      = 4'd7;
    localparam logic [3:0] S_YA      = 4'd8;
    localparam logic [3:0] S_DONE    = 4'd9;

    logic [3:0]       state;
    logic [WIDTH-1:0] p_q, x_q, y_q, z_q, e_q;
    logic [WIDTH-1:0] acc_q, zi2_q, zi3_q, xa_q;
    logic [WIDTH-1:0] x_aff_q, y_aff_q;
    logic [IW-1:0]    idx_q;
    logic             inf_q, busy_q, done_q;
    logic             mul_wait_q;
`ifdef JAC_ZONE_BYPASS_EN
    logic             one_q;
`endif

    logic             op_state, mul_start, mul_ready, mul_done;
    logic [WIDTH-1:0] mul_a, mul_b, mul_p;

    assign op_state  = (state >= S_EXP_SQ) && (state <= S_YA);
    // Issue exactly once per op: the cycle after issue mul_wait_q is set.
    assign mul_start = op_state && !mul_wait_q;
    assign mul_done  = mul_wait_q && mul_ready;

    always_comb begin
        mul_a = acc_q;
        mul_b = acc_q;
        case (state)
            S_EXP_MUL: begin mul_a = acc_q; mul_b = z_q;   end
            S_ZI3:     begin mul_a = zi2_q; mul_b = acc_q; end
            S_XA:      begin mul_a = x_q;   mul_b = zi2_q; end
            S_YA:      begin mul_a = y_q;   mul_b = zi3_q; end
            default:   begin mul_a = acc_q; mul_b = acc_q; end
        endcase
    end

    modular_multiplication #(
        .WIDTH (WIDTH),
        .STEP  (MUL_STEP)
    ) u_mul (
        .clk   (i_clk),
        .rst_n (~i_rst),
        .start (mul_start),
        .a     (mul_a),
        .b     (mul_b),
        .m     (p_q),
        .p     (mul_p),
        .ready (mul_ready)
    );

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state      <= S_IDLE;
            p_q        <= '0;
            x_q        <= '0;
            y_q        <= '0;
            z_q        <= '0;
            e_q        <= '0;
            acc_q      <= '0;
            zi2_q      <= '0;
            zi3_q      <= '0;
            xa_q       <= '0;
            x_aff_q    <= '0;
            y_aff_q    <= '0;
            idx_q      <= '0;
            inf_q      <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            mul_wait_q <= 1'b0;
`ifdef JAC_ZONE_BYPASS_EN
            one_q      <= 1'b0;
`endif
        end else begin
            done_q <= 1'b0;
            if (mul_start)     mul_wait_q <= 1'b1;
            else if (mul_done) mul_wait_q <= 1'b0;

            case (state)
                S_IDLE: begin
                    if (bus.i_start) begin
                        p_q    <= bus.p;
                        x_q    <= bus.X;
                        y_q    <= bus.Y;
                        z_q    <= bus.Z;
                        e_q    <= bus.p - WIDTH'(2);
                        acc_q  <= WIDTH'(1);
                        idx_q  <= IW'(WIDTH - 1);
                        busy_q <= 1'b1;
                        state  <= S_CHK;
                    end
                end
                S_CHK: begin
`ifdef JAC_ZONE_BYPASS_EN
                    one_q <= (z_q == WIDTH'(1));
                    if (z_q == '0 || z_q == WIDTH'(1)) state <= S_ZERO;
                    else                               state <= S_EXP_SQ;
`else
                    if (z_q == '0) state <= S_ZERO;
                    else           state <= S_EXP_SQ;
`endif
                end
                S_ZERO: begin
`ifdef JAC_ZONE_BYPASS_EN
                    x_aff_q <= one_q ? x_q : '0;
                    y_aff_q <= one_q ? y_q : '0;
                    inf_q   <= !one_q;
`else
                    x_aff_q <= '0;
                    y_aff_q <= '0;
                    inf_q   <= 1'b1;
`endif
                    done_q  <= 1'b1;
                    busy_q  <= 1'b0;
                    state   <= S_DONE;
                end
                S_EXP_SQ: begin
                    if (mul_done) begin
                        acc_q <= mul_p;
                        if (e_q[idx_q]) begin
                            state <= S_EXP_MUL;
                        end else if (idx_q == '0) begin
                            state <= S_ZI2;
                        end else begin
                            idx_q <= idx_q - IW'(1);
                        end
                    end
                end
                S_EXP_MUL: begin
                    if (mul_done) begin
                        acc_q <= mul_p;
                        if (idx_q == '0) begin
                            state <= S_ZI2;
                        end else begin
                            idx_q <= idx_q - IW'(1);
                            state <= S_EXP_SQ;
                        end
                    end
                end
                S_ZI2: begin
                    if (mul_done) begin
                        zi2_q <= mul_p;
                        state <= S_ZI3;
                    end
                end
                S_ZI3: begin
                    if (mul_done) begin
                        zi3_q <= mul_p;
                        state <= S_XA;
                    end
                end
                S_XA: begin
                    if (mul_done) begin
                        xa_q  <= mul_p;
                        state <= S_YA;
                    end
                end
                S_YA: begin
                    if (mul_done) begin
                        x_aff_q <= xa_q;
                        y_aff_q <= mul_p;
                        inf_q   <= 1'b0;
                        done_q  <= 1'b1;
                        busy_q  <= 1'b0;
                        state   <= S_DONE;
                    end
                end
                S_DONE:  state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

    assign bus.x_aff  = x_aff_q;
    assign bus.y_aff  = y_aff_q;
    assign bus.o_inf  = inf_q;
    assign bus.o_busy = busy_q;
    assign bus.o_done = done_q;
endmodule

// File: tb/tb_jacobian_to_affine.sv
module tb_jacobian_to_affine;
    localparam int W = 256;
    localparam int LIMIT = 20000;

    localparam logic [W-1:0] P256 = 256'hFFFFFFFF00000001000000000000000000000000FFFFFFFFFFFFFFFFFFFFFFFF;
    localparam logic [W-1:0] GX   = 256'h6B17D1F2E12C4247F8BCE6E563A440F277037D812DEB33A0F4A13945D898C296;
    localparam logic [W-1:0] GY   = 256'h4FE342E2FE1A7F9B8E7EB4A7C0F9E162BCE33576B315ECECBBB6406837BF51F5;

    logic i_clk = 1'b0;
    logic i_rst;
    always #5 i_clk = ~i_clk;

    jacobian_to_affine_if #(.WIDTH(W)) bus ();
    jacobian_to_affine #(.WIDTH(W)) dut (.i_clk(i_clk), .i_rst(i_rst), .bus(bus));

    typedef struct packed {
        logic [W-1:0] x;
        logic [W-1:0] y;
        logic         inf;
    } exp_t;

    exp_t sb[$];
    int checks = 0;
    int failures = 0;
    int done_cnt = 0;
    int mul_cnt = 0;

    always @(negedge i_clk) begin
        if (bus.o_done === 1'b1) done_cnt++;
        if (dut.mul_start === 1'b1) mul_cnt++;
    end

    function automatic logic [W-1:0] mod_add(input logic [W-1:0] a, input logic [W-1:0] b,
                                             input logic [W-1:0] m);
        logic [W:0] s;
        s = {1'b0, a} + {1'b0, b};
        if (s >= {1'b0, m}) s = s - {1'b0, m};
        return s[W-1:0];
    endfunction

    function automatic int popc(input logic [W-1:0] v);
        int n = 0;
        for (int i = 0; i < W; i++) if (v[i]) n++;
        return n;
    endfunction

    task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    task automatic start_conv(input logic [W-1:0] pp, input logic [W-1:0] xx,
                              input logic [W-1:0] yy, input logic [W-1:0] zz,
                              input logic [W-1:0] ex, input logic [W-1:0] ey, input logic ei);
        exp_t e;
        @(negedge i_clk);
        bus.p = pp; bus.X = xx; bus.Y = yy; bus.Z = zz;
        bus.i_start = 1'b1;
        e.x = ex; e.y = ey; e.inf = ei;
        sb.push_back(e);
        @(negedge i_clk);
        bus.i_start = 1'b0;
    endtask

    // Latency counts clock edges from the accepting edge to o_done visible.
    task automatic wait_done(output int lat);
        lat = 1;
        while (bus.o_done !== 1'b1 && lat < LIMIT) begin
            @(negedge i_clk);
            lat++;
        end
    endtask

    task automatic finish_conv(input string tag);
        exp_t e;
        check({tag, "_done_seen"}, bus.o_done, 1);
        check({tag, "_sb_nonempty"}, (sb.size() > 0), 1);
        if (sb.size() > 0) begin
            e = sb.pop_front();
            check({tag, "_x"}, bus.x_aff, e.x);
            check({tag, "_y"}, bus.y_aff, e.y);
            check({tag, "_inf"}, bus.o_inf, e.inf);
        end
        check({tag, "_busy_low"}, bus.o_busy, 0);
        @(negedge i_clk);
        check({tag, "_done_one_cycle"}, bus.o_done, 0);
    endtask

    logic [W-1:0] x4, y8, t;
    int lat, m0, d0, ops23, ops256;

    initial begin
        i_rst = 1'b1;
        bus.i_start = 1'b0;
        bus.p = '0; bus.X = '0; bus.Y = '0; bus.Z = '0;
        ops23  = W + popc(256'd21) + 4;
        ops256 = W + popc(P256 - 256'd2) + 4;
        t  = mod_add(GX, GX, P256);
        x4 = mod_add(t, t, P256);
        t  = mod_add(GY, GY, P256);
        t  = mod_add(t, t, P256);
        y8 = mod_add(t, t, P256);

        repeat (3) @(negedge i_clk);
        i_rst = 1'b0;
        @(negedge i_clk);
        check("rst_x", bus.x_aff, 0);
        check("rst_y", bus.y_aff, 0);
        check("rst_inf", bus.o_inf, 0);
        check("rst_busy", bus.o_busy, 0);
        check("rst_done", bus.o_done, 0);

        // Case 1: general point
        m0 = mul_cnt; d0 = done_cnt;
        start_conv(23, 5, 7, 2, 7, 21, 0);
        check("c1_busy", bus.o_busy, 1);
        wait_done(lat);
        finish_conv("c1");
        check("c1_mul_ops", mul_cnt - m0, ops23);
        check("c1_done_count", done_cnt - d0, 1);

        // Case 2: Z == 0 short path
        m0 = mul_cnt;
        start_conv(23, 9, 4, 0, 0, 0, 1);
        wait_done(lat);
        check("c2_latency", lat, 3);
        finish_conv("c2");
        check("c2_mul_ops", mul_cnt - m0, 0);

        // Case 4: Z == 1
        m0 = mul_cnt;
        start_conv(23, 5, 7, 1, 5, 7, 0);
        wait_done(lat);
`ifdef JAC_ZONE_BYPASS_EN
        check("c4_latency", lat, 3);
        finish_conv("c4");
        check("c4_mul_ops", mul_cnt - m0, 0);
`else
        check("c4_latency_full", (lat > 3), 1);
        finish_conv("c4");
        check("c4_mul_ops", mul_cnt - m0, ops23);
`endif

        // Case 5: start while busy is ignored
        d0 = done_cnt;
        start_conv(23, 5, 7, 2, 7, 21, 0);
        repeat (100) @(negedge i_clk);
        bus.X = 1; bus.Y = 1; bus.Z = 3;
        bus.i_start = 1'b1;
        @(negedge i_clk);
        bus.i_start = 1'b0;
        check("c5_busy_mid", bus.o_busy, 1);
        wait_done(lat);
        finish_conv("c5");
        repeat (5) @(negedge i_clk);
        check("c5_done_count", done_cnt - d0, 1);

        // Case 3: P-256 generator from (4Gx, 8Gy, 2)
        m0 = mul_cnt;
        start_conv(P256, x4, y8, 2, GX, GY, 0);
        wait_done(lat);
        finish_conv("c3");
        check("c3_mul_ops", mul_cnt - m0, ops256);

        // Case 6: reset mid-exponent, then rerun case 1
        d0 = done_cnt;
        start_conv(P256, x4, y8, 2, GX, GY, 0);
        repeat (600) @(negedge i_clk);
        check("c6_busy_mid", bus.o_busy, 1);
        i_rst = 1'b1;
        @(negedge i_clk);
        i_rst = 1'b0;
        if (sb.size() > 0) void'(sb.pop_front());
        check("c6_rst_x", bus.x_aff, 0);
        check("c6_rst_y", bus.y_aff, 0);
        check("c6_rst_inf", bus.o_inf, 0);
        check("c6_rst_busy", bus.o_busy, 0);
        check("c6_rst_done", bus.o_done, 0);
        repeat (200) @(negedge i_clk);
        check("c6_no_done", done_cnt - d0, 0);
        start_conv(23, 5, 7, 2, 7, 21, 0);
        wait_done(lat);
        finish_conv("c6_rerun");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
